// File: rtl/pulse_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_sched: time-triggered pulse command queue; define                  |
// | PULSE_SCHED_LATE_DROP_EN to drop late entries instead of issuing them.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pulse_sched #(
  parameter int CMD_WIDTH  = 79,
  parameter int TIME_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CMD_WIDTH-1:0]    cmd_in,
  input  logic [TIME_WIDTH-1:0]   cmd_time,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    run,
  input  logic                    timer_clr,
  input  logic                    flush,
  input  logic                    late_clr,
  output logic [CMD_WIDTH-1:0]    pulse_cmd_out,
  output logic                    pulse_write_en,
  output logic                    cstrobe_out,
  output logic                    late_err,
  output logic [$clog2(DEPTH):0]  count,
  output logic [TIME_WIDTH-1:0]   timer
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_ONE_CNT   = c_CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

`ifdef PULSE_SCHED_LATE_DROP_EN
  localparam bit c_LATE_DROP = 1'b1;
`else
  localparam bit c_LATE_DROP = 1'b0;
`endif

  logic [CMD_WIDTH-1:0]  r_mem_cmd  [DEPTH];
  logic [TIME_WIDTH-1:0] r_mem_time [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [TIME_WIDTH-1:0] r_timer;
  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [CMD_WIDTH-1:0]  r_cmd_out;
  logic                  r_write_en;
  logic                  r_late_err;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_cmp_en;
  logic                  w_match;
  logic                  w_late;
  logic                  w_issue;
  logic [TIME_WIDTH-1:0] w_diff;
  logic [CMD_WIDTH-1:0]  w_head_cmd;
  logic [TIME_WIDTH-1:0] w_head_time;

  // Ready is forced low during reset and whenever a flush is in progress.
  assign cmd_ready   = !reset && (r_count < c_DEPTH_CNT) && !flush;
  assign w_push      = cmd_valid && cmd_ready;
  assign w_head_cmd  = r_mem_cmd[r_rd_ptr];
  assign w_head_time = r_mem_time[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cmd[r_wr_ptr]  <= cmd_in;
      r_mem_time[r_wr_ptr] <= cmd_time;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_timer <= '0;
    else if (timer_clr) r_timer <= '0;
    else if (run)       r_timer <= r_timer + TIME_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_push) w_state_next = S_WAIT;
      S_WAIT: begin
        if (flush) w_state_next = S_IDLE;
        else if (w_pop && !w_push && (r_count == c_ONE_CNT)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Modular distance to the head time; an MSB of 1 means the time is past.
  always_comb begin
    w_cmp_en = (r_state == S_WAIT) && run && !flush;
    w_diff   = w_head_time - r_timer;
    w_match  = w_cmp_en && (w_diff == '0);
    w_late   = w_cmp_en && w_diff[TIME_WIDTH-1];
    w_pop    = w_match || w_late;
    w_issue  = w_match || (w_late && !c_LATE_DROP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_en <= 1'b0;
      r_cmd_out  <= '0;
      r_late_err <= 1'b0;
    end else begin
      r_write_en <= w_issue;
      if (w_issue) r_cmd_out <= w_head_cmd;
      if (w_late)        r_late_err <= 1'b1;
      else if (late_clr) r_late_err <= 1'b0;
    end
  end

  assign pulse_cmd_out  = r_cmd_out;
  assign pulse_write_en = r_write_en;
  assign cstrobe_out    = r_write_en;
  assign late_err       = r_late_err;
  assign count          = r_count;
  assign timer          = r_timer;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pulse_sched: randomized and directed bench for pulse_sched.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pulse_sched;

  localparam int CW    = 79;
  localparam int TW    = 8;
  localparam int DEPTH = 8;

`ifdef PULSE_SCHED_LATE_DROP_EN
  localparam bit LATE_DROP = 1'b1;
`else
  localparam bit LATE_DROP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [CW-1:0]          cmd_in = '0;
  logic [TW-1:0]          cmd_time = '0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic                   run = 1'b0;
  logic                   timer_clr = 1'b0;
  logic                   flush = 1'b0;
  logic                   late_clr = 1'b0;
  logic [CW-1:0]          pulse_cmd_out;
  logic                   pulse_write_en;
  logic                   cstrobe_out;
  logic                   late_err;
  logic [$clog2(DEPTH):0] count;
  logic [TW-1:0]          timer;

  pulse_sched #(.CMD_WIDTH(CW), .TIME_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_time(cmd_time),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .run(run),
    .timer_clr(timer_clr), .flush(flush), .late_clr(late_clr),
    .pulse_cmd_out(pulse_cmd_out), .pulse_write_en(pulse_write_en),
    .cstrobe_out(cstrobe_out), .late_err(late_err), .count(count),
    .timer(timer)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of pending (cmd, time) pairs.
  logic [CW-1:0] q_cmd  [$];
  logic [TW-1:0] q_time [$];
  logic [TW-1:0] m_timer;
  logic          m_we;
  logic [CW-1:0] m_cmd_out;
  logic          m_late;
  int            strobe_times [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    bit rdy, push, fire, late, i_run, i_clr, i_flush, i_lclr;
    logic [TW-1:0] diff;
    logic [CW-1:0] i_cmd;
    logic [TW-1:0] i_time;
    #1;
    i_run = run; i_clr = timer_clr; i_flush = flush; i_lclr = late_clr;
    i_cmd = cmd_in; i_time = cmd_time;
    rdy  = (q_cmd.size() < DEPTH) && !i_flush;
    check("cmd_ready", cmd_ready, rdy);
    push = cmd_valid && rdy;
    fire = 1'b0;
    late = 1'b0;
    if (q_cmd.size() != 0 && i_run && !i_flush) begin
      diff = q_time[0] - m_timer;
      late = diff[TW-1];
      fire = (diff == '0) || late;
    end
    @(posedge clk);
    #1;
    m_we = fire && (!late || !LATE_DROP);
    if (m_we) m_cmd_out = q_cmd[0];
    if (fire) begin
      void'(q_cmd.pop_front());
      void'(q_time.pop_front());
    end
    if (push) begin
      q_cmd.push_back(i_cmd);
      q_time.push_back(i_time);
    end
    if (i_flush) begin
      q_cmd.delete();
      q_time.delete();
    end
    if (late) m_late = 1'b1;
    else if (i_lclr) m_late = 1'b0;
    if (i_clr) m_timer = '0;
    else if (i_run) m_timer = m_timer + 8'd1;
    check("write_en", pulse_write_en, m_we);
    check("cstrobe", cstrobe_out, m_we);
    check("cmd_out", pulse_cmd_out, m_cmd_out);
    check("late_err", late_err, m_late);
    check("count", count, q_cmd.size());
    check("timer", timer, m_timer);
    if (pulse_write_en) strobe_times.push_back(int'(timer));
  endtask

  task automatic do_reset();
    cmd_valid = 0; run = 0; timer_clr = 0; flush = 0; late_clr = 0;
    reset = 1'b1;
    #1;
    check("rst_write_en", pulse_write_en, 1'b0);
    check("rst_cstrobe", cstrobe_out, 1'b0);
    check("rst_cmd_out", pulse_cmd_out, '0);
    check("rst_late_err", late_err, 1'b0);
    check("rst_count", count, 0);
    check("rst_timer", timer, 0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    q_cmd.delete(); q_time.delete();
    m_timer = '0; m_we = 0; m_cmd_out = '0; m_late = 0;
    strobe_times.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [CW-1:0] c);
    cmd_valid = 1'b1; cmd_in = c; cmd_time = t;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CW-1:0] a_cmd;
    bit seen;
    a_cmd = CW'(79'h1234_5678_9abc_def0_1357);
    #2;

    // Single on-time entry
    do_reset();
    run = 1;
    push(8'd10, a_cmd);
    repeat (15) tick();
    check("r42_nstrobe", strobe_times.size(), 1);
    if (strobe_times.size() > 0) check("r42_time", strobe_times[0], 11);
    check("r42_cmd", pulse_cmd_out, a_cmd);
    check("r42_late", late_err, 1'b0);

    // Fill the queue, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(100 + i), CW'(i + 1));
    cmd_valid = 1; cmd_in = CW'(99); cmd_time = 8'd110;
    #1;
    check("r43_ready", cmd_ready, 1'b0);
    check("r43_count", count, DEPTH);
    tick();
    cmd_valid = 0;
    run = 1;
    repeat (120) tick();
    check("r43_nstrobe", strobe_times.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < strobe_times.size(); i++)
      check("r43_order", strobe_times[i], 101 + i);

    // Late entry
    do_reset();
    run = 1;
    repeat (20) tick();
    push(8'd5, CW'(79'h55));
    repeat (5) tick();
    check("r44_late", late_err, 1'b1);
    check("r44_nstrobe", strobe_times.size(), LATE_DROP ? 0 : 1);
    check("r44_count", count, 0);

    // Timer wrap: an entry just past the wrap is not late
    do_reset();
    run = 1;
    for (int i = 0; i < 300 && m_timer != 8'd254; i++) tick();
    check("r45_preset", timer, 254);
    push(8'd1, CW'(79'hC));
    repeat (10) tick();
    check("r45_late", late_err, 1'b0);
    check("r45_nstrobe", strobe_times.size(), 1);
    if (strobe_times.size() > 0) check("r45_time", strobe_times[0], 2);

    // Flush, then reset during WAIT while a strobe is high
    do_reset();
    for (int i = 0; i < 3; i++) push(8'(50 + i), CW'(i + 7));
    check("r46_count3", count, 3);
    flush = 1;
    tick();
    flush = 0;
    check("r46_flushed", count, 0);
    run = 1;
    repeat (5) tick();
    check("r46_nostrobe", strobe_times.size(), 0);
    for (int i = 0; i < 3; i++) push(m_timer + 8'd3, CW'(i + 20));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = pulse_write_en;
    end
    check("r46_strobe_seen", seen, 1'b1);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      run       = ($urandom_range(0, 7) != 0);
      timer_clr = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 59) == 0);
      late_clr  = ($urandom_range(0, 19) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_in    = CW'({$urandom, $urandom, $urandom});
      if ($urandom_range(0, 5) == 0) cmd_time = m_timer - 8'($urandom_range(1, 30));
      else                           cmd_time = m_timer + 8'($urandom_range(1, 40));
      tick();
    end
    cmd_valid = 0; flush = 0; timer_clr = 0; late_clr = 0; run = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
